// File: rtl/ilkn_latency_test_sequencer.sv
// Run controller for the Interlaken latency build: resets the cores, waits for link-up,
// then runs NUM_RUNS send/receive iterations and accumulates round-trip latency statistics.
module ilkn_latency_test_sequencer #(
    parameter int NUM_RUNS       = 16,
    parameter int TIMEOUT_CYCLES = 1048575,
    parameter int RST_CYCLES     = 16,
    parameter int LAT_W          = 32
) (
    input  logic               init_clk,
    input  logic               clk_reset,
    input  logic               start,
    input  logic               rx_gt_locked,
    input  logic               rx_aligned,
    input  logic               tx_done,
    input  logic               tx_busy,
    input  logic               rx_done,
    input  logic               rx_busy,
    input  logic               tx_fail,
    input  logic               rx_failed,
    output logic               sys_reset,
    output logic               lbus_tx_rx_restart_in,
    output logic               s_axi_pm_tick,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [2:0]         error_code,
    output logic [7:0]         run_count,
    output logic [LAT_W-1:0]   lat_last,
    output logic [LAT_W-1:0]   lat_min,
    output logic [LAT_W-1:0]   lat_max,
    output logic [LAT_W+7:0]   lat_sum
);

    localparam int TMR_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [2:0] ERR_LOCK    = 3'd1;
    localparam logic [2:0] ERR_ALIGN   = 3'd2;
    localparam logic [2:0] ERR_TX_TO   = 3'd3;
    localparam logic [2:0] ERR_RX_TO   = 3'd4;
    localparam logic [2:0] ERR_IDLE_TO = 3'd5;
    localparam logic [2:0] ERR_TX_FAIL = 3'd6;
    localparam logic [2:0] ERR_RX_FAIL = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RESET_HOLD,
        S_LOCK_WAIT,
        S_ALIGN_WAIT,
        S_SEND,
        S_RECEIVE,
        S_IDLE_WAIT,
        S_RESTART,
        S_BUSY_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [7:0]         run_count_q, run_count_d;
    logic [LAT_W-1:0]   lat_last_q, lat_last_d;
    logic [LAT_W-1:0]   lat_min_q, lat_min_d;
    logic [LAT_W-1:0]   lat_max_q, lat_max_d;
    logic [LAT_W+7:0]   lat_sum_q, lat_sum_d;
    logic [2:0]         error_code_q, error_code_d;
    logic               sys_reset_q, sys_reset_d;
    logic               restart_q, restart_d;
    logic               pm_tick_q, pm_tick_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               fail_win;
    logic               align_win;
    logic               timed_out;

    always_ff @(posedge init_clk or posedge clk_reset) begin
        if (clk_reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            lat_cnt_q    <= '0;
            run_count_q  <= '0;
            lat_last_q   <= '0;
            lat_min_q    <= '1;
            lat_max_q    <= '0;
            lat_sum_q    <= '0;
            error_code_q <= '0;
            sys_reset_q  <= 1'b1;
            restart_q    <= 1'b0;
            pm_tick_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            lat_cnt_q    <= lat_cnt_d;
            run_count_q  <= run_count_d;
            lat_last_q   <= lat_last_d;
            lat_min_q    <= lat_min_d;
            lat_max_q    <= lat_max_d;
            lat_sum_q    <= lat_sum_d;
            error_code_q <= error_code_d;
            sys_reset_q  <= sys_reset_d;
            restart_q    <= restart_d;
            pm_tick_q    <= pm_tick_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next state and statistics. Core failures beat alignment loss, which beats
    // the normal handshake; the timeout only fires if the awaited event is absent.
    always_comb begin
        state_d      = state_q;
        error_code_d = error_code_q;
        run_count_d  = run_count_q;
        lat_last_d   = lat_last_q;
        lat_min_d    = lat_min_q;
        lat_max_d    = lat_max_q;
        lat_sum_d    = lat_sum_q;

        fail_win  = state_q inside {S_SEND, S_RECEIVE, S_IDLE_WAIT};
        align_win = state_q inside {S_SEND, S_RECEIVE, S_IDLE_WAIT, S_RESTART, S_BUSY_WAIT};
        timed_out = (timer_q >= TMR_W'(TIMEOUT_CYCLES - 1));

        if (fail_win && tx_fail) begin
            state_d      = S_ERROR;
            error_code_d = ERR_TX_FAIL;
        end else if (fail_win && rx_failed) begin
            state_d      = S_ERROR;
            error_code_d = ERR_RX_FAIL;
        end else if (align_win && !rx_aligned) begin
            state_d      = S_ERROR;
            error_code_d = ERR_ALIGN;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_d      = S_RESET_HOLD;
                        error_code_d = '0;
                        run_count_d  = '0;
                        lat_last_d   = '0;
                        lat_min_d    = '1;
                        lat_max_d    = '0;
                        lat_sum_d    = '0;
                    end
                end
                S_RESET_HOLD: begin
                    if (timer_q >= TMR_W'(RST_CYCLES - 1)) begin
                        state_d = S_LOCK_WAIT;
                    end
                end
                S_LOCK_WAIT: begin
                    if (rx_gt_locked) begin
                        state_d = S_ALIGN_WAIT;
                    end else if (timed_out) begin
                        state_d      = S_ERROR;
                        error_code_d = ERR_LOCK;
                    end
                end
                S_ALIGN_WAIT: begin
                    if (rx_aligned) begin
                        state_d = S_SEND;
                    end else if (timed_out) begin
                        state_d      = S_ERROR;
                        error_code_d = ERR_ALIGN;
                    end
                end
                S_SEND: begin
                    // rx_done seen here is deliberately ignored; it must be seen in RECEIVE
                    if (tx_done) begin
                        state_d = S_RECEIVE;
                    end else if (timed_out) begin
                        state_d      = S_ERROR;
                        error_code_d = ERR_TX_TO;
                    end
                end
                S_RECEIVE: begin
                    if (rx_done) begin
                        state_d     = S_IDLE_WAIT;
                        lat_last_d  = lat_cnt_q;
                        lat_sum_d   = lat_sum_q + (LAT_W+8)'(lat_cnt_q);
                        run_count_d = run_count_q + 8'd1;
                        if (lat_cnt_q < lat_min_q) begin
                            lat_min_d = lat_cnt_q;
                        end
                        if (lat_cnt_q > lat_max_q) begin
                            lat_max_d = lat_cnt_q;
                        end
                    end else if (timed_out) begin
                        state_d      = S_ERROR;
                        error_code_d = ERR_RX_TO;
                    end
                end
                S_IDLE_WAIT: begin
                    if (!tx_busy && !rx_busy) begin
                        state_d = (run_count_q == 8'(NUM_RUNS)) ? S_DONE : S_RESTART;
                    end else if (timed_out) begin
                        state_d      = S_ERROR;
                        error_code_d = ERR_IDLE_TO;
                    end
                end
                S_RESTART: begin
                    state_d = S_BUSY_WAIT;
                end
                S_BUSY_WAIT: begin
                    if (tx_busy && rx_busy) begin
                        state_d = S_SEND;
                    end else if (timed_out) begin
                        state_d      = S_ERROR;
                        error_code_d = ERR_IDLE_TO;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Timer, latency counter and registered outputs, all derived from the next state
    // so each output changes on the same edge as the state it belongs to.
    always_comb begin
        timer_d   = timer_q;
        lat_cnt_d = lat_cnt_q;

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + TMR_W'(1);
        end

        if (state_d == S_SEND && state_q != S_SEND) begin
            lat_cnt_d = LAT_W'(1);
        end else if ((state_q inside {S_SEND, S_RECEIVE}) && lat_cnt_q != '1) begin
            lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end

        sys_reset_d = state_d inside {S_IDLE, S_RESET_HOLD, S_ERROR};
        busy_d      = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERROR);
        restart_d   = (state_d == S_RESTART);
        pm_tick_d   = (state_d == S_DONE) && (state_q != S_DONE);
    end

    assign sys_reset             = sys_reset_q;
    assign lbus_tx_rx_restart_in = restart_q;
    assign s_axi_pm_tick         = pm_tick_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign error                 = error_q;
    assign error_code            = error_code_q;
    assign run_count             = run_count_q;
    assign lat_last              = lat_last_q;
    assign lat_min               = lat_min_q;
    assign lat_max               = lat_max_q;
    assign lat_sum               = lat_sum_q;

endmodule

// File: tb/tb_ilkn_latency_test_sequencer.sv
// Directed bench for the latency test sequencer: nominal runs, statistics, timeouts,
// failure priority, re-arming and asynchronous reset.
module tb_ilkn_latency_test_sequencer;

    localparam int NUM_RUNS   = 3;
    localparam int TIMEOUT    = 100;
    localparam int RST_CYCLES = 4;
    localparam int LAT_W      = 16;

    logic               init_clk = 1'b0;
    logic               clk_reset;
    logic               start;
    logic               rx_gt_locked;
    logic               rx_aligned;
    logic               tx_done;
    logic               tx_busy;
    logic               rx_done;
    logic               rx_busy;
    logic               tx_fail;
    logic               rx_failed;
    logic               sys_reset;
    logic               lbus_tx_rx_restart_in;
    logic               s_axi_pm_tick;
    logic               busy;
    logic               done;
    logic               error;
    logic [2:0]         error_code;
    logic [7:0]         run_count;
    logic [LAT_W-1:0]   lat_last;
    logic [LAT_W-1:0]   lat_min;
    logic [LAT_W-1:0]   lat_max;
    logic [LAT_W+7:0]   lat_sum;

    int n_checks = 0;
    int n_fail   = 0;
    int restart_cnt = 0;
    int pm_tick_cnt = 0;
    int restart_base;
    int tick_base;

    ilkn_latency_test_sequencer #(
        .NUM_RUNS(NUM_RUNS),
        .TIMEOUT_CYCLES(TIMEOUT),
        .RST_CYCLES(RST_CYCLES),
        .LAT_W(LAT_W)
    ) dut (
        .init_clk(init_clk),
        .clk_reset(clk_reset),
        .start(start),
        .rx_gt_locked(rx_gt_locked),
        .rx_aligned(rx_aligned),
        .tx_done(tx_done),
        .tx_busy(tx_busy),
        .rx_done(rx_done),
        .rx_busy(rx_busy),
        .tx_fail(tx_fail),
        .rx_failed(rx_failed),
        .sys_reset(sys_reset),
        .lbus_tx_rx_restart_in(lbus_tx_rx_restart_in),
        .s_axi_pm_tick(s_axi_pm_tick),
        .busy(busy),
        .done(done),
        .error(error),
        .error_code(error_code),
        .run_count(run_count),
        .lat_last(lat_last),
        .lat_min(lat_min),
        .lat_max(lat_max),
        .lat_sum(lat_sum)
    );

    always #5 init_clk = ~init_clk;

    always @(posedge init_clk) begin
        if (lbus_tx_rx_restart_in) restart_cnt <= restart_cnt + 1;
        if (s_axi_pm_tick) pm_tick_cnt <= pm_tick_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge init_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Start pulse through the reset-hold window; returns in the first LOCK_WAIT cycle.
    task automatic do_start();
        rx_gt_locked = 1'b0;
        rx_aligned   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hold_sys_reset", sys_reset, 1);
        chk("hold_busy", busy, 1);
        chk("hold_err_clr", {error, error_code}, 0);
        chk("hold_stats_clr", {run_count, lat_last, lat_max}, 0);
        chk("hold_min_clr", lat_min, 64'hFFFF);
        chk("hold_sum_clr", lat_sum, 0);
        ticks(RST_CYCLES - 1);
        chk("hold_last_cycle", sys_reset, 1);
        tick();
        chk("hold_released", sys_reset, 0);
    endtask

    // Lock arrives in the lock_dly-th LOCK_WAIT cycle, alignment likewise; ends in SEND cycle 1.
    task automatic bringup(input int lock_dly, input int align_dly);
        ticks(lock_dly - 1);
        rx_gt_locked = 1'b1;
        tick();
        ticks(align_dly - 1);
        rx_aligned = 1'b1;
        tick();
    endtask

    // tx_done in SEND cycle 1, rx_done in the RECEIVE cycle whose counter equals lat.
    task automatic send_receive(input int lat);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        ticks(lat - 2);
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        chk("lat_last", lat_last, 64'(lat));
    endtask

    task automatic finish_iter(input bit last);
        tick();
        if (!last) begin
            chk("restart_pulse", lbus_tx_rx_restart_in, 1);
            tx_busy = 1'b1;
            rx_busy = 1'b1;
            tick();
            chk("restart_one_cycle", lbus_tx_rx_restart_in, 0);
            tick();
            tx_busy = 1'b0;
            rx_busy = 1'b0;
        end else begin
            chk("done_reached", done, 1);
        end
    endtask

    task automatic do_run(input int lat, input bit last);
        send_receive(lat);
        finish_iter(last);
    endtask

    initial begin
        clk_reset = 1'b1;
        start = 1'b0;
        rx_gt_locked = 1'b0;
        rx_aligned = 1'b0;
        tx_done = 1'b0;
        tx_busy = 1'b0;
        rx_done = 1'b0;
        rx_busy = 1'b0;
        tx_fail = 1'b0;
        rx_failed = 1'b0;
        ticks(2);

        // Reset state
        chk("rst_sys_reset", sys_reset, 1);
        chk("rst_flags", {lbus_tx_rx_restart_in, s_axi_pm_tick, busy, done, error}, 0);
        chk("rst_error_code", error_code, 0);
        chk("rst_run_count", run_count, 0);
        chk("rst_lat_min", lat_min, 64'hFFFF);
        chk("rst_lat_max_last", {lat_max, lat_last}, 0);
        chk("rst_lat_sum", lat_sum, 0);
        clk_reset = 1'b0;
        ticks(3);
        chk("idle_sys_reset", sys_reset, 1);
        chk("idle_busy", busy, 0);

        // Nominal: three runs of latency 40; start during LOCK_WAIT ignored
        restart_base = restart_cnt;
        tick_base = pm_tick_cnt;
        do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored", sys_reset, 0);
        bringup(49, 50);
        do_run(40, 0);
        chk("run1_min", lat_min, 40);
        do_run(40, 0);
        send_receive(40);
        finish_iter(1);
        chk("nom_pm_tick", s_axi_pm_tick, 1);
        tick();
        chk("nom_pm_tick_once", s_axi_pm_tick, 0);
        chk("nom_done_held", {done, busy}, 2'b10);
        ticks(2);
        chk("nom_run_count", run_count, 3);
        chk("nom_min_max", {lat_min, lat_max}, {16'd40, 16'd40});
        chk("nom_sum", lat_sum, 120);
        chk("nom_restart_pulses", restart_cnt - restart_base, 2);
        chk("nom_pm_ticks", pm_tick_cnt - tick_base, 1);

        // Varying latency, re-armed from DONE
        do_start();
        bringup(5, 5);
        do_run(30, 0);
        do_run(55, 0);
        do_run(42, 1);
        chk("var_min", lat_min, 30);
        chk("var_max", lat_max, 55);
        chk("var_sum", lat_sum, 127);
        chk("var_run_count", run_count, 3);

        // Lock timeout after exactly TIMEOUT cycles in LOCK_WAIT
        do_start();
        ticks(TIMEOUT - 1);
        chk("lockto_not_yet", error, 0);
        tick();
        chk("lockto_error", error, 1);
        chk("lockto_code", error_code, 1);
        chk("lockto_sys_reset", sys_reset, 1);
        chk("lockto_busy", busy, 0);

        // rx_failed in RECEIVE of run 1
        do_start();
        bringup(3, 3);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        ticks(3);
        rx_failed = 1'b1;
        rx_done = 1'b1;
        tick();
        rx_failed = 1'b0;
        rx_done = 1'b0;
        chk("rxfail_error", error, 1);
        chk("rxfail_code", error_code, 7);
        chk("rxfail_run_count", run_count, 0);
        chk("rxfail_lat_last", lat_last, 0);
        ticks(2);
        chk("rxfail_code_held", error_code, 7);
        chk("rxfail_sum_frozen", lat_sum, 0);

        // Clean re-run: first run has tx_done and rx_done together in SEND
        do_start();
        bringup(3, 3);
        tx_done = 1'b1;
        rx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("simul_in_receive", {busy, run_count}, 9'h100);
        tick();
        rx_done = 1'b0;
        chk("simul_lat_last", lat_last, 2);
        chk("simul_run_count", run_count, 1);
        finish_iter(0);
        do_run(5, 0);
        do_run(7, 1);
        chk("rerun_min_max", {lat_min, lat_max}, {16'd2, 16'd7});
        chk("rerun_sum", lat_sum, 14);

        // tx_fail beats rx_failed and tx_done
        do_start();
        bringup(2, 2);
        tx_done = 1'b1;
        tx_fail = 1'b1;
        rx_failed = 1'b1;
        tick();
        tx_done = 1'b0;
        tx_fail = 1'b0;
        rx_failed = 1'b0;
        chk("txfail_code", {error, error_code}, 4'b1110);

        // Alignment loss in SEND of run 2
        do_start();
        bringup(2, 2);
        do_run(4, 0);
        rx_aligned = 1'b0;
        tick();
        chk("alignloss_code", {error, error_code}, 4'b1010);
        chk("alignloss_frozen", run_count, 1);

        // Asynchronous reset while in BUSY_WAIT
        do_start();
        bringup(2, 2);
        send_receive(20);
        ticks(2);
        chk("bw_run_count", run_count, 1);
        chk("bw_busy", busy, 1);
        #3 clk_reset = 1'b1;
        #1;
        chk("arst_sys_reset", sys_reset, 1);
        chk("arst_restart", lbus_tx_rx_restart_in, 0);
        chk("arst_run_count", run_count, 0);
        chk("arst_lat", {lat_last, lat_min}, 32'h0000FFFF);
        #2 clk_reset = 1'b0;
        tick();
        chk("arst_idle", {busy, done, error, sys_reset}, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ilkn_latency_test_sequencer.md
Name: ilkn_latency_test_sequencer

Overview:
Top-level run controller for the Interlaken latency-measurement build. It drives sys_reset into the driver and repeater example-design cores, waits for GT lock and RX alignment, then runs NUM_RUNS send/receive iterations. Between iterations it issues lbus_tx_rx_restart_in pulses. For each iteration it measures round-trip latency in init_clk cycles and accumulates min, max and sum statistics. It replaces the fixed two-packet inline state machine and adds per-state timeouts, error reporting and re-arming via start.

Parameters:
NUM_RUNS, 16, number of send/receive iterations per test (1..255).
TIMEOUT_CYCLES, 1048575, maximum cycles allowed in any wait state before an error is raised.
RST_CYCLES, 16, number of cycles sys_reset is held after start.
LAT_W, 32, width of the latency counter, lat_last, lat_min and lat_max.

Ports:
init_clk  in  1  sole clock.
clk_reset  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse; honoured only in IDLE, DONE or ERROR.
rx_gt_locked  in  1  AND of both cores' GT-locked indications.
rx_aligned  in  1  AND of both cores' RX-aligned indications.
tx_done  in  1  AND of both cores' tx_done.
tx_busy  in  1  AND of both cores' tx_busy.
rx_done  in  1  AND of both cores' rx_done.
rx_busy  in  1  AND of both cores' rx_busy.
tx_fail  in  1  OR of both cores' tx_fail.
rx_failed  in  1  OR of both cores' rx_failed.
sys_reset  out  1  reset to both cores.
lbus_tx_rx_restart_in  out  1  restart pulse to both cores.
s_axi_pm_tick  out  1  one-cycle performance-monitor snapshot pulse.
busy  out  1  high in every state except IDLE, DONE and ERROR.
done  out  1  high while in DONE.
error  out  1  high while in ERROR.
error_code  out  3  error cause: 1 lock timeout, 2 align timeout, 3 tx timeout, 4 rx timeout, 5 idle or busy-wait timeout, 6 tx_fail, 7 rx_failed.
run_count  out  8  number of completed iterations.
lat_last  out  LAT_W  latency of the most recent iteration.
lat_min  out  LAT_W  minimum latency in the current test.
lat_max  out  LAT_W  maximum latency in the current test.
lat_sum  out  LAT_W+8  sum of all latencies in the current test.

Behaviour:
- Reset values:
  - sys_reset = 1; all other outputs 0, except lat_min = all-ones.
  - State = IDLE.
- All outputs are registered. State and timer updates happen on the posedge of init_clk.
- Timer: cleared on every state change, increments otherwise, saturates. Reaching TIMEOUT_CYCLES in any wait state moves to ERROR with the matching error_code.
- IDLE:
  - sys_reset stays high.
  - On start: clear run_count, lat_last, lat_max and lat_sum; set lat_min = all-ones; go to RESET_HOLD.
- RESET_HOLD: sys_reset = 1 for exactly RST_CYCLES cycles, then drops to 0 and the state goes to LOCK_WAIT.
- LOCK_WAIT: rx_gt_locked = 1 -> ALIGN_WAIT.
- ALIGN_WAIT: rx_aligned = 1 -> SEND.
- SEND:
  - On entry, the latency counter = 1. It increments every cycle in SEND and RECEIVE and saturates at all-ones.
  - tx_done = 1 -> RECEIVE.
- RECEIVE: rx_done = 1 ->
  - lat_last = counter value in that cycle;
  - lat_min and lat_max updated (strict less-than / greater-than);
  - lat_sum += counter;
  - run_count += 1;
  - go to IDLE_WAIT.
- IDLE_WAIT: tx_busy = 0 and rx_busy = 0 ->
  - if run_count == NUM_RUNS, go to DONE;
  - otherwise go to RESTART.
- RESTART: lbus_tx_rx_restart_in = 1 for exactly one cycle -> BUSY_WAIT.
- BUSY_WAIT: tx_busy = 1 and rx_busy = 1 -> SEND.
- DONE:
  - s_axi_pm_tick = 1 in the first DONE cycle only.
  - done = 1 while in DONE.
  - start -> RESET_HOLD (statistics cleared as from IDLE).
- ERROR:
  - error = 1; error_code is held; sys_reset = 1.
  - Statistics are frozen.
  - start -> RESET_HOLD (statistics and error_code cleared).
- Failure priority: tx_fail or rx_failed = 1 during SEND, RECEIVE or IDLE_WAIT -> ERROR.
  - Failures take priority over done and timeout in the same cycle.
  - tx_fail takes priority over rx_failed.
- tx_done and rx_done in the same SEND cycle: move to RECEIVE only. rx_done must be sampled high in RECEIVE, so the minimum recorded latency is 2.
- Loss of rx_aligned in any state from SEND through BUSY_WAIT -> ERROR with code 2.
- start while busy is ignored.
- clk_reset asserted mid-run: outputs immediately take their reset values (asynchronous).
- lat_sum cannot overflow: 255 runs × (2^LAT_W − 1) fits in LAT_W+8 bits.

Test Plan:
- Nominal run: NUM_RUNS=2, lock at 50 cycles, align at 100, rx_done 40 cycles after SEND entry each run -> run_count=2, lat_last=lat_min=lat_max=40, lat_sum=80, done=1, exactly one s_axi_pm_tick and exactly one lbus_tx_rx_restart_in pulse.
- Varying latency: NUM_RUNS=3 with latencies 30, 55, 42 -> lat_min=30, lat_max=55, lat_sum=127, lat_last=42.
- Lock timeout: TIMEOUT_CYCLES=100 with rx_gt_locked held at 0 -> error=1 and error_code=1 exactly 100 cycles after LOCK_WAIT entry; sys_reset=1.
- Failure mid-run: rx_failed pulsed in RECEIVE of run 1 -> error_code=7, run_count=0; a following start re-runs the test cleanly to done.
- Simultaneous events: tx_done and rx_done high together in SEND -> state goes to RECEIVE; rx_done held high -> lat_last=2.
- Asynchronous reset: clk_reset asserted in BUSY_WAIT between clock edges -> sys_reset=1, lbus_tx_rx_restart_in=0, run_count=0 before the next edge; state=IDLE after release.
